// File: rtl/m3_reader.sv
// m3_reader: after a rising edge on start, reads every word of the M3 result RAM and
// streams it out on a valid/ready port. Define M3_READER_COLMAJOR_EN for column-major order.
module m3_reader #(
    parameter  int A        = 16,
    parameter  int C        = 24,
    parameter  int OUT_BITS = 32,
    localparam int M3_L     = A * C,
    localparam int AW       = $clog2(M3_L)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic [AW-1:0]       m3_rd_addr,
    output logic                m3_rd_ena,
    input  logic [OUT_BITS-1:0] m3_rd_data,
    output logic [OUT_BITS-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,
    output logic                done
);

    localparam int            RW       = (A > 1) ? $clog2(A) : 1;
    localparam int            CW       = (C > 1) ? $clog2(C) : 1;
    localparam logic [RW-1:0] ROW_LAST = RW'(A - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(C - 1);
    localparam logic [AW-1:0] C_AW     = AW'(C);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic                start_q, start_d;
    logic [RW-1:0]       row_q, row_d;
    logic [CW-1:0]       col_q, col_d;
    logic                inflight_q, inflight_d;
    logic                inflight_last_q, inflight_last_d;
    logic [OUT_BITS-1:0] fifo_data_q [2];
    logic [OUT_BITS-1:0] fifo_data_d [2];
    logic [1:0]          fifo_last_q, fifo_last_d;
    logic                wr_ptr_q, wr_ptr_d;
    logic                rd_ptr_q, rd_ptr_d;
    logic [1:0]          count_q, count_d;

    logic                start_edge;
    logic                pop;
    logic                issue;
    logic                elem_last;
    logic [2:0]          credit;

    always_ff @(posedge clk) begin
        // NOTE: every register here uses <= so all flops sample the same pre-edge values.
        if (rst) begin
            state_q         <= IDLE;
            start_q         <= 1'b0;
            row_q           <= '0;
            col_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            // NOTE: the two-word buffer is cleared so out_data reads 0 out of reset; a deep RAM would not be.
            fifo_data_q     <= '{default: '0};
            fifo_last_q     <= '0;
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
            count_q         <= '0;
        end else begin
            state_q         <= state_d;
            start_q         <= start_d;
            row_q           <= row_d;
            col_q           <= col_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            fifo_data_q     <= fifo_data_d;
            fifo_last_q     <= fifo_last_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
        end
    end

    assign out_valid  = (count_q != 2'd0);
    assign out_data   = fifo_data_q[rd_ptr_q];
    assign out_last   = out_valid & fifo_last_q[rd_ptr_q];
    assign done       = (state_q == DONE);
    assign m3_rd_ena  = issue;
    assign m3_rd_addr = AW'(row_q) * C_AW + AW'(col_q);

    assign start_edge = start & ~start_q;
    assign pop        = out_valid & out_ready;
    assign elem_last  = (row_q == ROW_LAST) && (col_q == COL_LAST);
    // Words the buffer is already committed to hold once this cycle's pop leaves.
    assign credit     = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case can infer a latch.
        state_d         = state_q;
        start_d         = start;
        row_d           = row_q;
        col_d           = col_q;
        inflight_d      = 1'b0;
        inflight_last_d = 1'b0;
        fifo_data_d     = fifo_data_q;
        fifo_last_d     = fifo_last_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        issue           = 1'b0;

        if (inflight_q) begin
            fifo_data_d[wr_ptr_q] = m3_rd_data;
            fifo_last_d[wr_ptr_q] = inflight_last_q;
            wr_ptr_d              = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, inflight_q} - {1'b0, pop};

        unique case (state_q)
            IDLE: begin
                if (start_edge) begin
                    row_d   = '0;
                    col_d   = '0;
                    state_d = READ;
                end
            end
            READ: begin
                if (credit < 3'd2) begin
                    issue           = 1'b1;
                    inflight_d      = 1'b1;
                    inflight_last_d = elem_last;
`ifdef M3_READER_COLMAJOR_EN
                    if (row_q == ROW_LAST) begin
                        row_d = '0;
                        col_d = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
`else
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
`endif
                    if (elem_last) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Looking at the post-pop count lets done rise the cycle after the last beat.
                if (count_d == 2'd0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!start) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_m3_reader.sv
// Self-checking bench for m3_reader: a cycle table for start-up/backpressure, then
// randomized readouts checked against an order/credit model of the readout.
module tb_m3_reader;

    localparam int A        = 16;
    localparam int C        = 24;
    localparam int OUT_BITS = 32;
    localparam int M3_L     = A * C;
    localparam int AW       = $clog2(M3_L);

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic                out_ready;
    logic [AW-1:0]       m3_rd_addr;
    logic                m3_rd_ena;
    logic [OUT_BITS-1:0] m3_rd_data = '0;
    logic [OUT_BITS-1:0] out_data;
    logic                out_valid;
    logic                out_last;
    logic                done;

    always #5 clk = ~clk;

    m3_reader #(.A(A), .C(C), .OUT_BITS(OUT_BITS)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .m3_rd_addr (m3_rd_addr),
        .m3_rd_ena  (m3_rd_ena),
        .m3_rd_data (m3_rd_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .done       (done)
    );

    // RAM content: each word holds its own address.
    function automatic logic [OUT_BITS-1:0] ram_word(input int addr);
        return OUT_BITS'(addr);
    endfunction

    always @(posedge clk) begin
        if (m3_rd_ena) m3_rd_data <= ram_word(int'(m3_rd_addr));
    end

    // Address of the k-th element in readout order.
    function automatic int exp_addr(input int k);
`ifdef M3_READER_COLMAJOR_EN
        return (k % A) * C + (k / A);
`else
        return k;
`endif
    endfunction

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Snapshot of the DUT taken mid-cycle.
    logic                s_rst, s_ena, s_valid, s_ready, s_last, s_done;
    logic [AW-1:0]       s_addr;
    logic [OUT_BITS-1:0] s_data;

    // Readout model state: reads issued and beats delivered in the current readout.
    int                  beat = 0, rd_cnt = 0, rd_total = 0, completed = 0;
    int                  first_xfer_cyc = 0, last_xfer_cyc = 0;
    logic                stall_prev = 1'b0, done_prev = 1'b0, prev_last = 1'b0;
    logic [OUT_BITS-1:0] prev_data = '0;

    task automatic monitor();
        logic pop;
        if (s_rst) begin
            beat       = 0;
            rd_cnt     = 0;
            stall_prev = 1'b0;
            done_prev  = 1'b0;
        end else begin
            pop = s_valid && s_ready;
            if (stall_prev) begin
                check("stall_valid", s_valid, 1);
                check("stall_data", s_data, prev_data);
                check("stall_last", s_last, prev_last);
            end
            if (s_ena) begin
                check("credit_below_2", (rd_cnt - beat - int'(pop)) < 2, 1);
                check("rd_addr", s_addr, exp_addr(rd_cnt));
                rd_cnt++;
                rd_total++;
            end
            if (pop) begin
                if (beat == 0) first_xfer_cyc = cyc;
                check("beat_data", s_data, ram_word(exp_addr(beat)));
                check("beat_last", s_last, beat == M3_L - 1);
                last_xfer_cyc = cyc;
                beat++;
            end
            if (s_done && !done_prev) begin
                check("beat_count", beat, M3_L);
                check("done_latency", cyc, last_xfer_cyc + 1);
                completed++;
                beat   = 0;
                rd_cnt = 0;
            end
            stall_prev = s_valid && !s_ready;
            prev_data  = s_data;
            prev_last  = s_last;
            done_prev  = s_done;
        end
    endtask

    // One clock cycle: inputs already driven; sample on the falling edge, then move past the next rising edge.
    task automatic tick();
        @(negedge clk);
        s_rst   = rst;
        s_ena   = m3_rd_ena;
        s_addr  = m3_rd_addr;
        s_valid = out_valid;
        s_ready = out_ready;
        s_data  = out_data;
        s_last  = out_last;
        s_done  = done;
        monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to_done(input int budget, input int low_pct);
        int c0;
        c0 = completed;
        for (int i = 0; i < budget && completed == c0; i++) begin
            out_ready = ($urandom_range(99) >= low_pct);
            tick();
        end
        check("done_timeout", completed != c0, 1);
    endtask

    typedef struct {
        logic start;
        logic ready;
        logic e_ena;
        int   e_addr;   // -1: not compared
        logic e_valid;
        int   e_data;
    } vec_t;

    function automatic vec_t mk(input logic st, input logic rdy, input logic ena,
                                input int addr, input logic vld, input int data);
        vec_t v;
        v.start   = st;
        v.ready   = rdy;
        v.e_ena   = ena;
        v.e_addr  = addr;
        v.e_valid = vld;
        v.e_data  = data;
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        int n_cyc;
        int r0;

        // Reset state, start edge, 20 cycles of out_ready=0, then release.
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 0, 1'b0, 0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 0, 1'b0, 0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, exp_addr(0), 1'b0, 0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, exp_addr(1), 1'b0, 0));
        for (int i = 4; i <= 20; i++)
            vecs.push_back(mk(1'b1, 1'b0, 1'b0, -1, 1'b1, exp_addr(0)));
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(1'b1, 1'b1, 1'b1, exp_addr(k + 2), 1'b1, exp_addr(k)));

        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        foreach (vecs[i]) begin
            start     = vecs[i].start;
            out_ready = vecs[i].ready;
            tick();
            check($sformatf("vec%0d_ena", i), s_ena, vecs[i].e_ena);
            if (vecs[i].e_addr >= 0)
                check($sformatf("vec%0d_addr", i), s_addr, vecs[i].e_addr);
            check($sformatf("vec%0d_valid", i), s_valid, vecs[i].e_valid);
            check($sformatf("vec%0d_data", i), s_data, ram_word(vecs[i].e_data));
            check($sformatf("vec%0d_last", i), s_last, 0);
            check($sformatf("vec%0d_done", i), s_done, 0);
        end
        run_to_done(2000, 0);

        // start held high after done: no second readout.
        r0 = rd_total;
        repeat (30) begin
            tick();
            check("done_held", s_done, 1);
        end
        check("no_relaunch_reads", rd_total, r0);

        // Drop start for one cycle, raise it: a full readout at full rate.
        start = 1'b0;
        tick();
        start = 1'b1;
        n_cyc = cyc;
        run_to_done(2000, 0);
        check("first_beat_latency", first_xfer_cyc, n_cyc + 3);
        check("full_rate_span", last_xfer_cyc - first_xfer_cyc, M3_L - 1);

        // Random backpressure, 30% of cycles with out_ready low.
        start = 1'b0;
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        run_to_done(6000, 30);

        // Reset after beat 100, with start held high across the reset.
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2000 && beat < 100; i++) begin
            out_ready = ($urandom_range(99) >= 30);
            tick();
        end
        check("reached_beat_100", beat >= 100, 1);
        rst       = 1'b1;
        start     = 1'b1;
        out_ready = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("rst_rd_ena", s_ena, 0);
        check("rst_rd_addr", s_addr, 0);
        check("rst_out_valid", s_valid, 0);
        check("rst_out_data", s_data, 0);
        check("rst_out_last", s_last, 0);
        check("rst_done", s_done, 0);
        run_to_done(2000, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
